// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding, port ids
// and the word-address legality check.
package dmem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Evaluated in 64 bits so addr+3 cannot wrap for any address width up to 62.
  function automatic logic addrLegal(input logic [63:0] addr, input logic [63:0] memBytes);
    return (addr[1:0] == 2'b00) && ((addr + 64'd3) < memBytes);
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker; rrPtr breaks ties when both ports request.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rrPtr,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 && req1) ? rrPtr : (req1 ? PORT1 : PORT0);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage (port 0)
// and the debug/loader (port 1); three cycles per transaction: IDLE, SERVE, DONE.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        stateReg;
  logic              rrPtrReg;
  logic              winnerReg;
  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;

  logic pickValid;
  logic pickWinner;
  logic cmdLegal;
  logic memActive;

  dmem_rr_pick uPick (
    .req0   (req0),
    .req1   (req1),
    .rrPtr  (rrPtrReg),
    .valid  (pickValid),
    .winner (pickWinner)
  );

  assign cmdLegal  = addrLegal(64'(addrReg), 64'(MEM_BYTES));
  // Gated by rst so a store interrupted by reset never reaches the memory.
  assign memActive = (stateReg == SERVE) && cmdLegal && !rst;

  assign mem_address = memActive ? addrReg  : '0;
  assign mem_wdata   = memActive ? wdataReg : '0;
  assign mem_write   = memActive &&  weReg;
  assign mem_read    = memActive && !weReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg  <= IDLE;
      rrPtrReg  <= PORT0;
      winnerReg <= PORT0;
      weReg     <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (pickValid) begin
            winnerReg <= pickWinner;
            weReg     <= (pickWinner == PORT1) ? we1    : we0;
            addrReg   <= (pickWinner == PORT1) ? addr1  : addr0;
            wdataReg  <= (pickWinner == PORT1) ? wdata1 : wdata0;
            rrPtrReg  <= ~pickWinner;
            stateReg  <= SERVE;
          end
        end
        SERVE: begin
          // Completion flags are registered here so they are visible throughout DONE.
          if (winnerReg == PORT1) begin
            done1 <= 1'b1;
            err1  <= ~cmdLegal;
            if (!cmdLegal)   rdata1 <= '0;
            else if (!weReg) rdata1 <= mem_rdata;
          end else begin
            done0 <= 1'b1;
            err0  <= ~cmdLegal;
            if (!cmdLegal)   rdata0 <= '0;
            else if (!weReg) rdata0 <= mem_rdata;
          end
          stateReg <= DONE;
        end
        DONE:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-array memory model plus per-port drivers;
// expectations are queued at issue time and compared on every done pulse.
module tb_dmem_arbiter;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] r0;
    logic [31:0] r1;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err0, err1, mem_write, mem_read;
  logic [31:0] rdata0, rdata1, mem_address, mem_wdata, mem_rdata;

  logic [7:0]  memArr [256];
  logic [7:0]  refMem [256];
  logic [31:0] expRd  [2];
  exp_t        expQ [$];
  cmd_t        cmdQ0 [$];
  cmd_t        cmdQ1 [$];
  int          checkCount = 0;
  int          passCount  = 0;
  bit          forbidMem  = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Big-endian byte memory: combinational read, posedge write.
  logic [7:0] ma;
  assign ma = mem_address[7:0];
  assign mem_rdata = {memArr[ma], memArr[8'(ma + 8'd1)], memArr[8'(ma + 8'd2)], memArr[8'(ma + 8'd3)]};

  always @(posedge clk) begin
    if (mem_write) begin
      memArr[ma]              <= mem_wdata[31:24];
      memArr[8'(ma + 8'd1)]   <= mem_wdata[23:16];
      memArr[8'(ma + 8'd2)]   <= mem_wdata[15:8];
      memArr[8'(ma + 8'd3)]   <= mem_wdata[7:0];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: legality, store effect and expected rdata of both ports.
  function automatic void issue(input logic port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
    logic  legal;
    exp_t  e;
    cmd_t  c;
    legal = (addr[1:0] == 2'b00) && ((33'(addr) + 33'd3) < 33'd256);
    if (!legal) expRd[port] = '0;
    else if (we) begin
      refMem[addr[7:0]]   = wdata[31:24];
      refMem[addr[7:0]+1] = wdata[23:16];
      refMem[addr[7:0]+2] = wdata[15:8];
      refMem[addr[7:0]+3] = wdata[7:0];
    end else
      expRd[port] = {refMem[addr[7:0]], refMem[addr[7:0]+1], refMem[addr[7:0]+2], refMem[addr[7:0]+3]};
    e.port = port; e.err = ~legal; e.r0 = expRd[0]; e.r1 = expRd[1];
    expQ.push_back(e);
    c.we = we; c.addr = addr; c.wdata = wdata;
    if (port) cmdQ1.push_back(c); else cmdQ0.push_back(c);
  endfunction

  // Holds req high across back-to-back commands; drops it after the last done.
  task automatic drivePort(input int p, input bit checkLat);
    cmd_t c;
    int   cyc;
    bit   first = 1'b1;
    bit   seen;
    @(negedge clk);
    while ((p == 0) ? (cmdQ0.size() != 0) : (cmdQ1.size() != 0)) begin
      if (p == 0) begin
        c = cmdQ0.pop_front();
        req0 = 1'b1; we0 = c.we; addr0 = c.addr; wdata0 = c.wdata;
      end else begin
        c = cmdQ1.pop_front();
        req1 = 1'b1; we1 = c.we; addr1 = c.addr; wdata1 = c.wdata;
      end
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        cyc++;
        seen = (p == 0) ? done0 : done1;
      end
      if (!seen) checkVal($sformatf("timeout_p%0d", p), 32'd0, 32'd1);
      else if (checkLat) checkVal($sformatf("latency_p%0d", p), 32'(cyc), first ? 32'd2 : 32'd3);
      first = 1'b0;
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (forbidMem) checkVal("memIdle", {30'd0, mem_read, mem_write}, 32'd0);
    if (done0 || done1) begin
      checkVal("doneExcl", {31'd0, done0 & done1}, 32'd0);
      if (expQ.size() == 0) checkVal("unexpectedDone", 32'd1, 32'd0);
      else begin
        e = expQ.pop_front();
        checkVal("grantPort", {31'd0, done1}, {31'd0, e.port});
        checkVal("err", {31'd0, done1 ? err1 : err0}, {31'd0, e.err});
        checkVal("rdata0", rdata0, e.r0);
        checkVal("rdata1", rdata1, e.r1);
        $display("txn port=%0d err=%0d rdata0=%h rdata1=%h", done1, done1 ? err1 : err0, rdata0, rdata1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      memArr[i] = 8'h00;
      refMem[i] = 8'h00;
    end
    expRd[0] = '0;
    expRd[1] = '0;
    repeat (3) @(negedge clk);
    checkVal("rstDone", {30'd0, done0, done1}, 32'd0);
    checkVal("rstErr", {30'd0, err0, err1}, 32'd0);
    checkVal("rstRdata", rdata0 | rdata1, 32'd0);
    checkVal("rstMem", mem_address | mem_wdata | {30'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;

    // Both requesters contend from the same edge; grants must go 0,1,0,1.
    issue(1'b0, 1'b1, 32'h40, 32'hA5A5_0001);
    issue(1'b1, 1'b1, 32'h44, 32'h5A5A_0002);
    issue(1'b0, 1'b0, 32'h44, 32'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0);
    fork
      drivePort(0, 1'b0);
      drivePort(1, 1'b0);
    join

    // Port 0 store then load, single requester.
    issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    drivePort(0, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    drivePort(0, 1'b1);

    // Illegal port-1 accesses never touch the memory.
    forbidMem = 1'b1;
    issue(1'b1, 1'b0, 32'h13, 32'h0);
    issue(1'b1, 1'b0, 32'hFD, 32'h0);
    issue(1'b1, 1'b0, 32'h100, 32'h0);
    issue(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    drivePort(1, 1'b1);
    @(negedge clk);
    forbidMem = 1'b0;

    // Last legal word.
    issue(1'b1, 1'b1, 32'hFC, 32'hCAFE_F00D);
    drivePort(1, 1'b1);
    issue(1'b0, 1'b0, 32'hFC, 32'h0);
    drivePort(0, 1'b1);

    // Reset while a store is in SERVE.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0;
    expRd[0] = '0;
    expRd[1] = '0;
    repeat (4) @(negedge clk);
    checkVal("rstStore", {memArr[8'h20], memArr[8'h21], memArr[8'h22], memArr[8'h23]}, 32'd0);
    checkVal("rstRdataMid", rdata0 | rdata1, 32'd0);

    // Port 0 holds req across two transactions; port 1 data must stay put.
    issue(1'b1, 1'b1, 32'h80, 32'h0BAD_F00D);
    drivePort(1, 1'b1);
    issue(1'b1, 1'b0, 32'h80, 32'h0);
    drivePort(1, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 1'b0, 32'hFC, 32'h0);
    drivePort(0, 1'b1);

    repeat (5) @(negedge clk);
    checkVal("pending", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got 0 expected 1");
    $fatal(1, "simulation time limit reached");
  end

endmodule
